alu_seq: RTL and testbench

- Registered, parametrised successor of the 8-bit single-cycle ALU.
- Operand width is generic, and the operation set adds SUB/XOR, a true barrel shifter/rotator and a multi-cycle shift-add multiplier.
- Uses a START/BUSY/DONE handshake and registered RESULT and flags.
- Sits between the register file and writeback mux; the control unit stalls the PC while BUSY is high.

---
 rtl/alu_seq.sv | 155 +++++++++++++++
 tb/tb_alu_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered, parametrised ALU with a START/BUSY/DONE handshake.
// Single-cycle ops complete in one edge; MUL runs a WIDTH-step shift-add sequence.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       select,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] OpFwd = 4'b0000;
  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpSub = 4'b0010;
  localparam logic [3:0] OpAnd = 4'b0011;
  localparam logic [3:0] OpOr  = 4'b0100;
  localparam logic [3:0] OpXor = 4'b0101;
  localparam logic [3:0] OpSll = 4'b0110;
  localparam logic [3:0] OpSrl = 4'b0111;
  localparam logic [3:0] OpSra = 4'b1000;
  localparam logic [3:0] OpRol = 4'b1001;
  localparam logic [3:0] OpRor = 4'b1010;
  localparam logic [3:0] OpMul = 4'b1011;

  typedef enum logic {StIdle, StMul} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 carry_q, carry_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [SHW-1:0]       cnt_q, cnt_d;

  logic [SHW-1:0]       amt;
  logic [WIDTH:0]       ext_sum, ext_diff, ext_sll, ext_srl, ext_sra;
  logic [2*WIDTH-1:0]   rol_t, ror_t, acc_step;
  logic [WIDTH-1:0]     sc_res;
  logic                 sc_carry;

  assign amt = data2[SHW-1:0];

  // Shifts use one extra bit so the last bit shifted out lands in the carry position.
  always_comb begin
    ext_sum  = {1'b0, data1} + {1'b0, data2};
    ext_diff = {1'b0, data1} - {1'b0, data2};
    ext_sll  = {1'b0, data1} << amt;
    ext_srl  = {data1, 1'b0} >> amt;
    ext_sra  = $signed({data1, 1'b0}) >>> amt;
    rol_t    = {data1, data1} << amt;
    ror_t    = {data1, data1} >> amt;
    sc_res   = '0;
    sc_carry = 1'b0;
    case (select)
      OpFwd: sc_res = data2;
      OpAdd: {sc_carry, sc_res} = ext_sum;
      OpSub: {sc_carry, sc_res} = ext_diff;
      OpAnd: sc_res = data1 & data2;
      OpOr:  sc_res = data1 | data2;
      OpXor: sc_res = data1 ^ data2;
      OpSll: {sc_carry, sc_res} = ext_sll;
      OpSrl: {sc_res, sc_carry} = ext_srl;
      OpSra: {sc_res, sc_carry} = ext_sra;
      OpRol: sc_res = rol_t[2*WIDTH-1:WIDTH];
      OpRor: sc_res = ror_t[WIDTH-1:0];
      default: begin
        sc_res   = '0;
        sc_carry = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      StIdle: begin
        if (start) begin
          if (select == OpMul) begin
            state_d  = StMul;
            mcand_d  = {{WIDTH{1'b0}}, data1};
            mplier_d = data2;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            result_d = sc_res;
            carry_d  = sc_carry;
            done_d   = 1'b1;
          end
        end
      end
      StMul: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d  = StIdle;
          result_d = acc_step[WIDTH-1:0];
          carry_d  = |acc_step[2*WIDTH-1:WIDTH];
          done_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      result_q <= '0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result = result_q;
  assign zero   = ~|result_q;
  assign neg    = result_q[WIDTH-1];
  assign carry  = carry_q;
  assign busy   = (state_q == StMul);
  assign done   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8 and WIDTH=16.
module tb_alu_seq;

  logic        clk;
  logic        reset;
  logic        start8, start16;
  logic [3:0]  select8, select16;
  logic [7:0]  data1_8, data2_8, result8;
  logic [15:0] data1_16, data2_16, result16;
  logic        zero8, neg8, carry8, busy8, done8;
  logic        zero16, neg16, carry16, busy16, done16;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(8)) u_alu8 (
    .clk(clk), .reset(reset), .start(start8), .select(select8), .data1(data1_8),
    .data2(data2_8), .result(result8), .zero(zero8), .neg(neg8), .carry(carry8),
    .busy(busy8), .done(done8)
  );

  alu_seq #(.WIDTH(16)) u_alu16 (
    .clk(clk), .reset(reset), .start(start16), .select(select16), .data1(data1_16),
    .data2(data2_16), .result(result16), .zero(zero16), .neg(neg16), .carry(carry16),
    .busy(busy16), .done(done16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue8(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
    start8  = 1'b1;
    select8 = sel;
    data1_8 = a;
    data2_8 = b;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (result8 !== 8'h00) begin n_fail++; $display("FAIL rst_result: got %h want 00", result8); end
    n_checks++; if (zero8 !== 1'b1) begin n_fail++; $display("FAIL rst_zero: got %b want 1", zero8); end
    n_checks++; if (neg8 !== 1'b0) begin n_fail++; $display("FAIL rst_neg: got %b want 0", neg8); end
    n_checks++; if (carry8 !== 1'b0) begin n_fail++; $display("FAIL rst_carry: got %b want 0", carry8); end
    n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy8); end
    n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done8); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add;
    issue8(4'b0001, 8'hFF, 8'h01);
    @(negedge clk);
    start8 = 1'b0;
    n_checks++; if (result8 !== 8'h00) begin n_fail++; $display("FAIL add_result: got %h want 00", result8); end
    n_checks++; if (zero8 !== 1'b1) begin n_fail++; $display("FAIL add_zero: got %b want 1", zero8); end
    n_checks++; if (carry8 !== 1'b1) begin n_fail++; $display("FAIL add_carry: got %b want 1", carry8); end
    n_checks++; if (neg8 !== 1'b0) begin n_fail++; $display("FAIL add_neg: got %b want 0", neg8); end
    n_checks++; if (done8 !== 1'b1) begin n_fail++; $display("FAIL add_done: got %b want 1", done8); end
    n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL add_busy: got %b want 0", busy8); end
    @(negedge clk);
    n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse: got %b want 0", done8); end
    n_checks++; if (carry8 !== 1'b1) begin n_fail++; $display("FAIL add_hold: got %b want 1", carry8); end
  endtask

  task automatic test_back_to_back;
    issue8(4'b0010, 8'h03, 8'h05);
    @(negedge clk);
    n_checks++; if (result8 !== 8'hFE) begin n_fail++; $display("FAIL sub_result: got %h want fe", result8); end
    n_checks++; if (carry8 !== 1'b1) begin n_fail++; $display("FAIL sub_borrow: got %b want 1", carry8); end
    n_checks++; if (neg8 !== 1'b1) begin n_fail++; $display("FAIL sub_neg: got %b want 1", neg8); end
    n_checks++; if (done8 !== 1'b1) begin n_fail++; $display("FAIL sub_done: got %b want 1", done8); end
    issue8(4'b0101, 8'hAA, 8'hAA);
    @(negedge clk);
    start8 = 1'b0;
    n_checks++; if (result8 !== 8'h00) begin n_fail++; $display("FAIL xor_result: got %h want 00", result8); end
    n_checks++; if (zero8 !== 1'b1) begin n_fail++; $display("FAIL xor_zero: got %b want 1", zero8); end
    n_checks++; if (carry8 !== 1'b0) begin n_fail++; $display("FAIL xor_carry: got %b want 0", carry8); end
    n_checks++; if (done8 !== 1'b1) begin n_fail++; $display("FAIL xor_done_b2b: got %b want 1", done8); end
    @(negedge clk);
    n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL xor_done_pulse: got %b want 0", done8); end
  endtask

  task automatic test_shifts;
    logic [3:0] sel  [6] = '{4'b1000, 4'b0110, 4'b1010, 4'b0111, 4'b1001, 4'b0110};
    logic [7:0] amt  [6] = '{8'd3, 8'd1, 8'd4, 8'd3, 8'd1, 8'd0};
    logic [7:0] expr [6] = '{8'hF2, 8'h2C, 8'h69, 8'h12, 8'h2D, 8'h96};
    logic       expc [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      issue8(sel[i], 8'h96, amt[i]);
      @(negedge clk);
      start8 = 1'b0;
      n_checks++;
      if (result8 !== expr[i] || carry8 !== expc[i] || done8 !== 1'b1) begin
        n_fail++;
        $display("FAIL shift_%0d sel=%b amt=%0d: got res=%h c=%b done=%b want res=%h c=%b done=1",
                 i, sel[i], amt[i], result8, carry8, done8, expr[i], expc[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mul;
    int cycles;
    issue8(4'b1011, 8'h0D, 8'h0B);
    @(negedge clk);
    start8  = 1'b0;
    data1_8 = 8'hFF;
    data2_8 = 8'hFF;
    select8 = 4'b0001;
    n_checks++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL mul_busy_start: got %b want 1", busy8); end
    n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL mul_done_start: got %b want 0", done8); end
    cycles = 0;
    while (done8 !== 1'b1 && cycles < 20) begin
      start8 = (cycles == 2 || cycles == 5);
      @(negedge clk);
      cycles++;
      if (done8 !== 1'b1) begin
        n_checks++;
        if (busy8 !== 1'b1 || result8 !== 8'h96) begin
          n_fail++;
          $display("FAIL mul_busy_c%0d: got busy=%b res=%h want busy=1 res=96", cycles, busy8, result8);
        end
      end
    end
    start8 = 1'b0;
    n_checks++; if (cycles !== 8) begin n_fail++; $display("FAIL mul_latency: got %0d want 8", cycles); end
    n_checks++; if (result8 !== 8'h8F) begin n_fail++; $display("FAIL mul_result: got %h want 8f", result8); end
    n_checks++; if (carry8 !== 1'b0) begin n_fail++; $display("FAIL mul_carry: got %b want 0", carry8); end
    n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL mul_busy_end: got %b want 0", busy8); end
    @(negedge clk);
    n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL mul_done_pulse: got %b want 0", done8); end
    issue8(4'b1011, 8'h20, 8'h10);
    @(negedge clk);
    start8 = 1'b0;
    cycles = 0;
    while (done8 !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    n_checks++; if (cycles !== 8) begin n_fail++; $display("FAIL mul2_latency: got %0d want 8", cycles); end
    n_checks++; if (result8 !== 8'h00) begin n_fail++; $display("FAIL mul2_result: got %h want 00", result8); end
    n_checks++; if (zero8 !== 1'b1) begin n_fail++; $display("FAIL mul2_zero: got %b want 1", zero8); end
    n_checks++; if (carry8 !== 1'b1) begin n_fail++; $display("FAIL mul2_carry: got %b want 1", carry8); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul;
    int dones;
    issue8(4'b0000, 8'h00, 8'hA5);
    @(negedge clk);
    start8 = 1'b0;
    n_checks++; if (result8 !== 8'hA5 || neg8 !== 1'b1) begin n_fail++; $display("FAIL fwd_result: got %h neg=%b want a5 neg=1", result8, neg8); end
    issue8(4'b1011, 8'h0D, 8'h0B);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++; if (result8 !== 8'h00) begin n_fail++; $display("FAIL abort_result: got %h want 00", result8); end
    n_checks++; if (zero8 !== 1'b1 || neg8 !== 1'b0) begin n_fail++; $display("FAIL abort_flags: got z=%b n=%b want z=1 n=0", zero8, neg8); end
    n_checks++; if (busy8 !== 1'b0 || done8 !== 1'b0 || carry8 !== 1'b0) begin n_fail++; $display("FAIL abort_ctrl: got b=%b d=%b c=%b want 0 0 0", busy8, done8, carry8); end
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) dones++;
    end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", dones); end
    issue8(4'b0001, 8'h02, 8'h03);
    @(negedge clk);
    start8 = 1'b0;
    n_checks++; if (result8 !== 8'h05 || done8 !== 1'b1) begin n_fail++; $display("FAIL post_add: got %h done=%b want 05 done=1", result8, done8); end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    issue8(4'b1110, 8'h5A, 8'h3C);
    @(negedge clk);
    start8 = 1'b0;
    n_checks++; if (result8 !== 8'h00) begin n_fail++; $display("FAIL ill_result: got %h want 00", result8); end
    n_checks++; if (zero8 !== 1'b1 || carry8 !== 1'b0) begin n_fail++; $display("FAIL ill_flags: got z=%b c=%b want z=1 c=0", zero8, carry8); end
    n_checks++; if (done8 !== 1'b1 || busy8 !== 1'b0) begin n_fail++; $display("FAIL ill_done: got d=%b b=%b want d=1 b=0", done8, busy8); end
    @(negedge clk);
    n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL ill_done_pulse: got %b want 0", done8); end
  endtask

  task automatic test_mul16;
    int cycles;
    start16  = 1'b1;
    select16 = 4'b1011;
    data1_16 = 16'h1234;
    data2_16 = 16'h0010;
    @(negedge clk);
    start16  = 1'b0;
    data1_16 = 16'hFFFF;
    cycles = 0;
    while (done16 !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (done16 !== 1'b1 && busy16 !== 1'b1) begin
        n_checks++; n_fail++;
        $display("FAIL mul16_busy_c%0d: got 0 want 1", cycles);
      end
    end
    n_checks++; if (cycles !== 16) begin n_fail++; $display("FAIL mul16_latency: got %0d want 16", cycles); end
    n_checks++; if (result16 !== 16'h2340) begin n_fail++; $display("FAIL mul16_result: got %h want 2340", result16); end
    n_checks++; if (carry16 !== 1'b1) begin n_fail++; $display("FAIL mul16_carry: got %b want 1", carry16); end
    n_checks++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL mul16_busy_end: got %b want 0", busy16); end
    @(negedge clk);
  endtask

  initial begin
    reset    = 1'b0;
    start8   = 1'b0;
    select8  = 4'b0000;
    data1_8  = 8'h00;
    data2_8  = 8'h00;
    start16  = 1'b0;
    select16 = 4'b0000;
    data1_16 = 16'h0000;
    data2_16 = 16'h0000;
    test_reset();
    test_add();
    test_back_to_back();
    test_shifts();
    test_mul();
    test_reset_mid_mul();
    test_illegal();
    test_mul16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
